// File: rtl/ifu_pkg.sv
// ifu_pkg: shared FSM state encoding, opcode field layout and the built-in program image
// used by instr_fetch_unit and ifu_mem.
package ifu_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    HALT  = 2'd2
  } ifu_state_t;

  localparam logic [1:0] OPC_STOP = 2'b11;
  // the opcode occupies the top OPC_W bits of every instruction word
  localparam int OPC_W = 2;

  localparam int PROG_LEN = 16;
  localparam logic [7:0] DEFAULT_PROG [PROG_LEN] = '{
    8'h48, 8'h61, 8'h6c, 8'h74, 8'h21, 8'h05, 8'h3a, 8'h7e,
    8'h90, 8'ha5, 8'hc3, 8'h12, 8'h34, 8'h56, 8'h78, 8'h9a
  };

  function automatic logic [7:0] default_word(input int unsigned addr);
    if (addr < PROG_LEN) return DEFAULT_PROG[addr[3:0]];
    return 8'h00;
  endfunction

endpackage

// File: rtl/ifu_mem.sv
// ifu_mem: instruction store with a registered read port. With IFU_PROG_LOAD_EN it is a
// writable RAM; otherwise a constant ROM holding the package default program.
module ifu_mem
  import ifu_pkg::*;
#(
  parameter  int DATA_W = 8,
  parameter  int DEPTH  = 32,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data,
  input  logic              we,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data
);

`ifdef IFU_PROG_LOAD_EN
  logic [DATA_W-1:0] mem [DEPTH];

  // rd_addr is the address the fetcher will sit on next, so a write landing on it must be
  // forwarded to keep rd_data equal to the live contents at that address.
  always_ff @(posedge clk) begin
    if (we) mem[wr_addr] <= wr_data;
    if (we && (wr_addr == rd_addr)) rd_data <= wr_data;
    else                            rd_data <= mem[rd_addr];
  end
`else
  logic unused_wr;
  assign unused_wr = &{1'b0, we, wr_addr, wr_data};

  always_ff @(posedge clk) begin
    rd_data <= DATA_W'(default_word(32'(rd_addr)));
  end
`endif

endmodule

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: sequential instruction fetcher with stall, redirect and STOP halt.
// Program memory is writable through prog_* only when IFU_PROG_LOAD_EN is defined.
//   state | meaning
//   IDLE  | after clear, waiting for start
//   FETCH | issuing one word per unstalled cycle
//   HALT  | STOP issued, waiting for start
module instr_fetch_unit
  import ifu_pkg::*;
#(
  parameter  int DATA_W = 8,
  parameter  int DEPTH  = 32,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              clear,
  input  logic              start,
  input  logic              stall,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_addr,
  input  logic              prog_we,
  input  logic [ADDR_W-1:0] prog_addr,
  input  logic [DATA_W-1:0] prog_data,
  output logic [DATA_W-1:0] instruction,
  output logic              instr_valid,
  output logic [ADDR_W-1:0] pc,
  output logic              halted
);

  ifu_state_t        state;
  logic [DATA_W-1:0] mem_word;
  logic [ADDR_W-1:0] pc_nxt;
  logic              word_is_stop;

  // The memory is addressed with the next pc, so mem_word always holds mem[pc] and the
  // STOP decision can be made on the same edge that issues the word.
  ifu_mem #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_mem (
    .clk     (clk),
    .rd_addr (pc_nxt),
    .rd_data (mem_word),
    .we      (prog_we),
    .wr_addr (prog_addr),
    .wr_data (prog_data)
  );

  assign word_is_stop = (mem_word[DATA_W-1 -: OPC_W] == OPC_STOP);

  always_comb begin
    pc_nxt = pc;
    if (clear) begin
      pc_nxt = '0;
    end else begin
      case (state)
        IDLE, HALT: begin
          if (start) pc_nxt = '0;
        end
        FETCH: begin
          if (redirect)                      pc_nxt = redirect_addr;
          else if (!stall && !word_is_stop)  pc_nxt = pc + ADDR_W'(1);
        end
        default: pc_nxt = '0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (clear) begin
      state       <= IDLE;
      pc          <= '0;
      instruction <= '0;
      instr_valid <= 1'b0;
      halted      <= 1'b0;
    end else begin
      pc <= pc_nxt;
      case (state)
        IDLE: begin
          if (start) state <= FETCH;
        end
        FETCH: begin
          if (redirect) begin
            instr_valid <= 1'b0;
          end else if (!stall) begin
            instruction <= mem_word;
            instr_valid <= 1'b1;
            if (word_is_stop) begin
              state  <= HALT;
              halted <= 1'b1;
            end
          end
        end
        HALT: begin
          instr_valid <= 1'b0;
          if (start) begin
            state  <= FETCH;
            halted <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb_instr_fetch_unit: directed and random checks of instr_fetch_unit against a
// behavioural fetch model; exercises the prog_* port when IFU_PROG_LOAD_EN is defined.
module tb_instr_fetch_unit;

  localparam int DATA_W = 8;
  localparam int DEPTH  = 32;
  localparam int ADDR_W = 5;

  logic              clk = 1'b0;
  logic              clear = 1'b1;
  logic              start = 1'b0;
  logic              stall = 1'b0;
  logic              redirect = 1'b0;
  logic [ADDR_W-1:0] redirect_addr = '0;
  logic              prog_we = 1'b0;
  logic [ADDR_W-1:0] prog_addr = '0;
  logic [DATA_W-1:0] prog_data = '0;
  logic [DATA_W-1:0] instruction;
  logic              instr_valid;
  logic [ADDR_W-1:0] pc;
  logic              halted;

  instr_fetch_unit #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) dut (
    .clk           (clk),
    .clear         (clear),
    .start         (start),
    .stall         (stall),
    .redirect      (redirect),
    .redirect_addr (redirect_addr),
    .prog_we       (prog_we),
    .prog_addr     (prog_addr),
    .prog_data     (prog_data),
    .instruction   (instruction),
    .instr_valid   (instr_valid),
    .pc            (pc),
    .halted        (halted)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // behavioural model: a running flag plus a halted flag instead of an FSM
  logic [7:0] m_mem [DEPTH];
  bit         m_running;
  bit         m_halted;
  bit         m_valid;
  logic [7:0] m_instr;
  int         m_pc;

  function automatic logic [7:0] rom_word(input int a);
    case (a)
      0: return 8'h48;  1: return 8'h61;  2: return 8'h6c;  3: return 8'h74;
      4: return 8'h21;  5: return 8'h05;  6: return 8'h3a;  7: return 8'h7e;
      8: return 8'h90;  9: return 8'ha5; 10: return 8'hc3; 11: return 8'h12;
     12: return 8'h34; 13: return 8'h56; 14: return 8'h78; 15: return 8'h9a;
      default: return 8'h00;
    endcase
  endfunction

  task automatic model_edge();
    logic [7:0] rd;
    rd = m_mem[m_pc];
    if (clear) begin
      m_running = 0; m_halted = 0; m_pc = 0; m_instr = 8'h00; m_valid = 0;
    end else if (!m_running) begin
      m_valid = 0;
      if (start) begin
        m_running = 1; m_halted = 0; m_pc = 0;
      end
    end else if (redirect) begin
      m_pc = int'(redirect_addr);
      m_valid = 0;
    end else if (!stall) begin
      m_instr = rd;
      m_valid = 1;
      if (rd[7:6] == 2'b11) begin
        m_running = 0; m_halted = 1;
      end else begin
        m_pc = (m_pc + 1) % DEPTH;
      end
    end
`ifdef IFU_PROG_LOAD_EN
    if (prog_we) m_mem[prog_addr] = prog_data;
`endif
  endtask

  task automatic check_outputs(input string tag);
    checks++;
    assert (instruction === m_instr) else begin
      errors++; $error("FAIL %s instruction: got %h expected %h", tag, instruction, m_instr);
    end
    checks++;
    assert (instr_valid === m_valid) else begin
      errors++; $error("FAIL %s instr_valid: got %b expected %b", tag, instr_valid, m_valid);
    end
    checks++;
    assert (pc === ADDR_W'(m_pc)) else begin
      errors++; $error("FAIL %s pc: got %0d expected %0d", tag, pc, m_pc);
    end
    checks++;
    assert (halted === m_halted) else begin
      errors++; $error("FAIL %s halted: got %b expected %b", tag, halted, m_halted);
    end
  endtask

  task automatic expect_const(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++; $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step(input string tag);
    @(posedge clk);
    model_edge();
    #1;
    check_outputs(tag);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int         n_words;
    logic [7:0] last_word;
    bit         done;

    for (int i = 0; i < DEPTH; i++) m_mem[i] = rom_word(i);

    // load the default image through the program port while held in clear
    for (int i = 0; i < DEPTH; i++) begin
      prog_we   = 1'b1;
      prog_addr = ADDR_W'(i);
      prog_data = rom_word(i);
      step("preload");
    end
    prog_we = 1'b0;
    step("clear");
    expect_const("reset_instruction", 32'(instruction), 32'h0);
    expect_const("reset_valid", 32'(instr_valid), 32'h0);
    expect_const("reset_pc", 32'(pc), 32'h0);
    expect_const("reset_halted", 32'(halted), 32'h0);

    clear = 1'b0;
    redirect = 1'b1; redirect_addr = 5'd9;
    step("idle_redirect");
    expect_const("idle_redirect_pc", 32'(pc), 32'h0);
    redirect = 1'b0;

    start = 1'b1;
    step("start");
    start = 1'b0;
    expect_const("start_no_valid", 32'(instr_valid), 32'h0);

    step("fetch0");
    expect_const("first_word", 32'(instruction), 32'h48);
    expect_const("first_valid", 32'(instr_valid), 32'h1);
    step("fetch1");
    expect_const("second_word", 32'(instruction), 32'h61);
    expect_const("second_pc", 32'(pc), 32'h2);

    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step("stall");
      expect_const("stall_word", 32'(instruction), 32'h61);
      expect_const("stall_pc", 32'(pc), 32'h2);
    end
    stall = 1'b0;
    step("resume");
    expect_const("resume_word", 32'(instruction), 32'h6c);

    redirect = 1'b1; redirect_addr = 5'd7; stall = 1'b1;
    step("redirect");
    expect_const("redirect_drop", 32'(instr_valid), 32'h0);
    redirect = 1'b0; stall = 1'b0;
    step("redirect_target");
    expect_const("redirect_word", 32'(instruction), 32'h7e);
    expect_const("redirect_pc", 32'(pc), 32'h8);

    step("run8");
    step("run9");
    step("stop");
    expect_const("stop_word", 32'(instruction), 32'hc3);
    expect_const("stop_halted", 32'(halted), 32'h1);
    expect_const("stop_pc", 32'(pc), 32'd10);
    step("halt_hold");
    expect_const("halt_valid", 32'(instr_valid), 32'h0);
    redirect = 1'b1; redirect_addr = 5'd3;
    step("halt_redirect");
    expect_const("halt_redirect_pc", 32'(pc), 32'd10);
    redirect = 1'b0;

    // full program from a restart out of HALT
    start = 1'b1;
    step("restart");
    start = 1'b0;
    expect_const("restart_halted", 32'(halted), 32'h0);
    n_words = 0; last_word = 8'h00; done = 0;
    for (int i = 0; i < 40 && !done; i++) begin
      step("program_run");
      if (instr_valid === 1'b1) begin
        n_words++;
        last_word = instruction;
      end
      if (halted === 1'b1) done = 1;
    end
    expect_const("program_reached_stop", 32'(halted), 32'h1);
    expect_const("program_word_count", 32'(n_words), 32'd11);
    expect_const("program_last_word", 32'(last_word), 32'hc3);
    step("program_after");
    expect_const("program_after_valid", 32'(instr_valid), 32'h0);
    expect_const("program_after_pc", 32'(pc), 32'd10);

    // wrap past DEPTH-1 by starting beyond the STOP word
    start = 1'b1;
    step("wrap_start");
    start = 1'b0;
    redirect = 1'b1; redirect_addr = 5'd11;
    step("wrap_redirect");
    redirect = 1'b0;
    for (int i = 0; i < 21; i++) step("wrap_run");
    expect_const("wrap_last_word", 32'(instruction), 32'h00);
    expect_const("wrap_pc", 32'(pc), 32'h0);
    step("wrap_next");
    expect_const("wrap_next_word", 32'(instruction), 32'h48);
    expect_const("wrap_next_pc", 32'(pc), 32'h1);
    step("pre_clear");

    clear = 1'b1;
    step("mid_clear");
    expect_const("mid_clear_instruction", 32'(instruction), 32'h0);
    expect_const("mid_clear_valid", 32'(instr_valid), 32'h0);
    expect_const("mid_clear_pc", 32'(pc), 32'h0);
    clear = 1'b0;
`ifdef IFU_PROG_LOAD_EN
    prog_we = 1'b1; prog_addr = 5'd0; prog_data = 8'h2b;
`endif
    step("idle_write");
    prog_we = 1'b0;
    start = 1'b1;
    step("clear_restart");
    start = 1'b0;
    step("clear_first");
`ifdef IFU_PROG_LOAD_EN
    expect_const("clear_first_word", 32'(instruction), 32'h2b);
`else
    expect_const("clear_first_word", 32'(instruction), 32'h48);
`endif

    // random traffic, including program writes (ignored by the ROM build)
    for (int i = 0; i < 400; i++) begin
      clear         = ($urandom_range(49) == 0);
      start         = ($urandom_range(7) == 0);
      stall         = ($urandom_range(3) == 0);
      redirect      = ($urandom_range(9) == 0);
      redirect_addr = ADDR_W'($urandom);
      prog_we       = ($urandom_range(3) == 0);
      prog_addr     = ADDR_W'($urandom);
      prog_data     = 8'($urandom);
      step("random");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
